wib_pll_lock_supervisor: RTL and testbench
==========================================

# wib_pll_lock_supervisor

Supervises the system PLL (50 MHz refclk in; 100/50/40 MHz out). It drives the PLL's active-high `rst` and consumes its `locked` output. It issues a timed PLL reset pulse, waits for lock with a timeout, and requires lock to be held continuously for a qualification window before declaring clocks ready. Any later loss of lock is counted and triggers an automatic re-lock sequence. `sys_ready` gates release of the resets for logic running on the PLL output clocks.

## Interface
- `RST_PULSE_CYC`, default 16: length in refclk cycles of the `pll_rst` pulse; must be ≥2.
- `LOCK_STABLE_CYC`, default 1024: number of consecutive locked cycles required before `sys_ready`; must be ≥2.
- `LOCK_TIMEOUT_CYC`, default 65536: number of cycles allowed in WAIT_LOCK before the PLL is reset again.
- `CNT_W`, default 8: width of the event counters.

Ports:
- `refclk` in 1: the single clock, a 50 MHz free-running board oscillator that also feeds the PLL.
- `rst` in 1: asynchronous, active-low (0 = reset) block reset.
- `pll_locked` in 1: the PLL `locked` output. It is asynchronous and is synchronized internally with 2 flops.
- `relock_req` in 1: single-cycle request from software/control to force a PLL re-lock.
- `pll_rst` out 1: active-high, drives the PLL `rst`.
- `sys_ready` out 1: high only in state RUN.
- `state` out 2: current state (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3).
- `loss_cnt` out CNT_W: count of lock losses detected in RUN; saturates at all-ones.
- `timeout_cnt` out CNT_W: count of WAIT_LOCK timeouts; saturates at all-ones.

## Operation
- `lock_s` is `pll_locked` after the 2-flop synchronizer. Both synchronizer flops clear to 0 on reset.
- A single cycle counter `cyc` is shared by all states. It clears to 0 on every state transition.

States and transitions:
- RESET_PLL: `pll_rst`=1. After RST_PULSE_CYC cycles in this state, go to WAIT_LOCK. `relock_req` is ignored here.
- WAIT_LOCK: `pll_rst`=0.
  - `lock_s`=1 → STABLE.
  - Otherwise, when `cyc` reaches LOCK_TIMEOUT_CYC-1 → RESET_PLL and `timeout_cnt`+1.
  - `relock_req` → RESET_PLL.
- STABLE: `pll_rst`=0.
  - `lock_s`=0 → WAIT_LOCK. This does not count as a loss, and the timeout window restarts.
  - `lock_s` held 1 for LOCK_STABLE_CYC cycles → RUN.
  - `relock_req` → RESET_PLL.
- RUN: `sys_ready`=1.
  - `lock_s`=0 → RESET_PLL and `loss_cnt`+1.
  - `relock_req` → RESET_PLL with no count increment.
  - If `relock_req` and `lock_s`=0 occur in the same cycle, `relock_req` wins and `loss_cnt` is unchanged.

Outputs:
- `pll_rst` and `sys_ready` are registered or decoded directly from the state register, so they are glitch-free.
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on `rst`.

Reset behaviour:
- While `rst`=0: state=RESET_PLL, `pll_rst`=1, `sys_ready`=0, `loss_cnt`=0, `timeout_cnt`=0, `cyc`=0, synchronizer=0.
- The PLL is therefore held in reset for the full duration of block reset.
- If `rst` is asserted mid-sequence, the block returns to RESET_PLL asynchronously, with counters cleared.
- After `rst` deasserts, a full RST_PULSE_CYC pulse is issued.

## Timing
- `pll_rst` pulse: high for exactly RST_PULSE_CYC refclk cycles from entry to RESET_PLL, measured from reset release or from the edge that enters the state.
- Synchronizer latency: `pll_locked` sampled high at edge k gives `lock_s`=1 after edge k+1.
- Lock to ready:
  - If `pll_locked` rises before edge k and then stays high, STABLE is entered at edge k+2.
  - RUN and `sys_ready`=1 follow LOCK_STABLE_CYC edges later, at edge k+2+LOCK_STABLE_CYC.
- Loss of lock: if `pll_locked` falls before edge k, `sys_ready`=0 and `pll_rst`=1 take effect at edge k+2.
- `relock_req` sampled at edge k gives `sys_ready`=0 and `pll_rst`=1 after edge k.
- Timeout: with no lock, `pll_rst` re-asserts exactly LOCK_TIMEOUT_CYC cycles after WAIT_LOCK entry. `timeout_cnt` updates on the same edge.

## Test plan
All scenarios use RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, CNT_W=4.
- Power-up: hold `rst`=0 for 10 cycles, release, then raise `pll_locked` 5 cycles after `pll_rst` falls.
  - Expected: `pll_rst`=1 through reset plus 4 cycles, and `sys_ready`=1 exactly 10 edges after the edge that samples `pll_locked`=1.
  - Counters remain 0.
- Lock glitch in STABLE: drop `pll_locked` for 1 cycle at the 5th STABLE cycle.
  - Expected: return to WAIT_LOCK with `loss_cnt`=0, then a full 8-cycle qualification before `sys_ready`.
- Loss in RUN: deassert `pll_locked`.
  - Expected: `sys_ready`=0 and `pll_rst`=1 two edges later, `loss_cnt`=1, then a 4-cycle pulse and an automatic re-lock.
- Timeout: keep `pll_locked`=0.
  - Expected: `pll_rst` pulses of 4 cycles every 36 cycles, with `timeout_cnt` incrementing 1, 2, … and saturating at 15 after 17 timeouts.
- Relock priority: in RUN, pulse `relock_req` in the same cycle that `lock_s` falls.
  - Expected: RESET_PLL entered, `loss_cnt` unchanged.
  - `relock_req` while in RESET_PLL gives no pulse extension.
- Async reset mid-STABLE: assert `rst`=0 between clock edges.
  - Expected: `pll_rst`=1, `sys_ready`=0, `state`=0 immediately without a clock edge, and counters cleared.

Source files
------------

// File: rtl/wib_pll_lock_supervisor.sv
// wib_pll_lock_supervisor: sequences the PLL reset, qualifies lock and re-locks on loss or request.
module wib_pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);
  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;
  localparam int MAX_A = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
  localparam int MAX_C = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
  localparam int CW    = $clog2(MAX_C) + 1;
  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cyc;
  logic [CNT_W-1:0] r_loss_cnt;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [1:0]       w_next;
  logic             w_lock_s;
  logic             w_loss;
  logic             w_tmo;
  assign w_lock_s = r_sync[1];
  // relock_req takes priority over every lock-driven transition, so a simultaneous loss is not counted
  always_comb begin
    w_next = r_state;
    w_loss = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      S_RESET_PLL: w_next = (r_cyc == CW'(RST_PULSE_CYC - 1)) ? S_WAIT_LOCK : S_RESET_PLL;
      S_WAIT_LOCK: begin
        if (relock_req) w_next = S_RESET_PLL;
        else if (w_lock_s) w_next = S_STABLE;
        else if (r_cyc == CW'(LOCK_TIMEOUT_CYC - 1)) begin
          w_next = S_RESET_PLL;
          w_tmo  = 1'b1;
        end
      end
      S_STABLE: begin
        if (relock_req) w_next = S_RESET_PLL;
        else if (!w_lock_s) w_next = S_WAIT_LOCK;
        else if (r_cyc == CW'(LOCK_STABLE_CYC - 1)) w_next = S_RUN;
      end
      default: begin
        if (relock_req) w_next = S_RESET_PLL;
        else if (!w_lock_s) begin
          w_next = S_RESET_PLL;
          w_loss = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_sync        <= '0;
      r_state       <= S_RESET_PLL;
      r_cyc         <= '0;
      r_loss_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], pll_locked};
      r_state <= w_next;
      r_cyc   <= (w_next != r_state) ? '0 : r_cyc + CW'(1);
      if (w_loss && !(&r_loss_cnt)) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      if (w_tmo && !(&r_timeout_cnt)) r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
    end
  end
  assign pll_rst     = (r_state == S_RESET_PLL);
  assign sys_ready   = (r_state == S_RUN);
  assign state       = r_state;
  assign loss_cnt    = r_loss_cnt;
  assign timeout_cnt = r_timeout_cnt;
endmodule

// File: tb/tb_wib_pll_lock_supervisor.sv
// tb_wib_pll_lock_supervisor: directed scenarios with hand-computed edge timing.
module tb_wib_pll_lock_supervisor;
  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_ready;
  logic [1:0] state;
  logic [3:0] loss_cnt;
  logic [3:0] timeout_cnt;
  int checks = 0;
  int failures = 0;

  wib_pll_lock_supervisor #(
    .RST_PULSE_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(32), .CNT_W(4)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_ready(sys_ready), .state(state),
    .loss_cnt(loss_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic go_run;
    bit ok = 0;
    pll_locked = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = sys_ready;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL go_run: sys_ready=%0b required 1 within 100 cycles", sys_ready); end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if ({state, pll_rst, sys_ready} !== 4'b0010) begin failures++; $display("FAIL reset_outputs: state=%0d pll_rst=%0b sys_ready=%0b required 0/1/0", state, pll_rst, sys_ready); end
    checks++;
    if ({loss_cnt, timeout_cnt} !== 8'h00) begin failures++; $display("FAIL reset_counters: loss=%0d timeout=%0d required 0/0", loss_cnt, timeout_cnt); end
  endtask

  task automatic test_power_up;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (pll_rst !== 1'b1) begin failures++; $display("FAIL pulse_hold: pll_rst=%0b required 1", pll_rst); end
    tick();
    checks++;
    if (pll_rst !== 1'b0 || state !== 2'd1) begin failures++; $display("FAIL pulse_end: pll_rst=%0b state=%0d required 0/1", pll_rst, state); end
    repeat (5) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL sync_latency: state=%0d required 1", state); end
    tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL stable_entry: state=%0d required 2", state); end
    repeat (7) tick();
    checks++;
    if (sys_ready !== 1'b0) begin failures++; $display("FAIL ready_early: sys_ready=%0b required 0", sys_ready); end
    tick();
    checks++;
    if (sys_ready !== 1'b1 || state !== 2'd3) begin failures++; $display("FAIL ready_at_10: sys_ready=%0b state=%0d required 1/3", sys_ready, state); end
    checks++;
    if ({loss_cnt, timeout_cnt} !== 8'h00) begin failures++; $display("FAIL powerup_counters: loss=%0d timeout=%0d required 0/0", loss_cnt, timeout_cnt); end
  endtask

  task automatic test_loss_in_run;
    pll_locked = 1'b0;
    tick();
    tick();
    checks++;
    if (sys_ready !== 1'b1) begin failures++; $display("FAIL loss_early: sys_ready=%0b required 1", sys_ready); end
    tick();
    checks++;
    if ({sys_ready, pll_rst} !== 2'b01 || loss_cnt !== 4'd1) begin failures++; $display("FAIL loss_react: sys_ready=%0b pll_rst=%0b loss=%0d required 0/1/1", sys_ready, pll_rst, loss_cnt); end
    repeat (3) tick();
    checks++;
    if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pulse_hold: pll_rst=%0b required 1", pll_rst); end
    tick();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL loss_pulse_end: state=%0d required 1", state); end
  endtask

  task automatic test_stable_glitch;
    pll_locked = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL glitch_stable_entry: state=%0d required 2", state); end
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL glitch_latency: state=%0d required 2", state); end
    tick();
    checks++;
    if (state !== 2'd1 || loss_cnt !== 4'd1) begin failures++; $display("FAIL glitch_back_to_wait: state=%0d loss=%0d required 1/1", state, loss_cnt); end
    tick();
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL glitch_restable: state=%0d required 2", state); end
    repeat (7) tick();
    checks++;
    if (sys_ready !== 1'b0) begin failures++; $display("FAIL glitch_qual_early: sys_ready=%0b required 0", sys_ready); end
    tick();
    checks++;
    if (sys_ready !== 1'b1) begin failures++; $display("FAIL glitch_qual_done: sys_ready=%0b required 1", sys_ready); end
  endtask

  task automatic test_relock_priority;
    pll_locked = 1'b0;
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++;
    if (state !== 2'd0 || loss_cnt !== 4'd1) begin failures++; $display("FAIL relock_vs_loss: state=%0d loss=%0d required 0/1", state, loss_cnt); end
    repeat (4) tick();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL relock_pulse_end: state=%0d required 1", state); end
    go_run();
    relock_req = 1'b1;
    pll_locked = 1'b0;
    tick();
    relock_req = 1'b0;
    checks++;
    if ({sys_ready, pll_rst} !== 2'b01 || loss_cnt !== 4'd1) begin failures++; $display("FAIL relock_run: sys_ready=%0b pll_rst=%0b loss=%0d required 0/1/1", sys_ready, pll_rst, loss_cnt); end
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tick();
    checks++;
    if (pll_rst !== 1'b1) begin failures++; $display("FAIL relock_in_reset_hold: pll_rst=%0b required 1", pll_rst); end
    tick();
    checks++;
    if (pll_rst !== 1'b0 || state !== 2'd1) begin failures++; $display("FAIL relock_no_extend: pll_rst=%0b state=%0d required 0/1", pll_rst, state); end
  endtask

  task automatic test_timeout;
    for (int t = 1; t <= 17; t++) begin
      repeat (31) tick();
      checks++;
      if (state !== 2'd1) begin failures++; $display("FAIL timeout_wait_%0d: state=%0d required 1", t, state); end
      tick();
      checks++;
      if (pll_rst !== 1'b1 || timeout_cnt !== 4'((t > 15) ? 15 : t)) begin failures++; $display("FAIL timeout_fire_%0d: pll_rst=%0b timeout=%0d required 1/%0d", t, pll_rst, timeout_cnt, (t > 15) ? 15 : t); end
      repeat (4) tick();
      checks++;
      if (state !== 2'd1) begin failures++; $display("FAIL timeout_pulse_%0d: state=%0d required 1", t, state); end
    end
  endtask

  task automatic test_async_reset;
    bit ok = 0;
    pll_locked = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (state == 2'd2);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL areset_reach_stable: state=%0d required 2", state); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, pll_rst, sys_ready} !== 4'b0010) begin failures++; $display("FAIL areset_outputs: state=%0d pll_rst=%0b sys_ready=%0b required 0/1/0", state, pll_rst, sys_ready); end
    checks++;
    if ({loss_cnt, timeout_cnt} !== 8'h00) begin failures++; $display("FAIL areset_counters: loss=%0d timeout=%0d required 0/0", loss_cnt, timeout_cnt); end
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (pll_rst !== 1'b1) begin failures++; $display("FAIL areset_pulse_hold: pll_rst=%0b required 1", pll_rst); end
    tick();
    checks++;
    if (pll_rst !== 1'b0) begin failures++; $display("FAIL areset_pulse_end: pll_rst=%0b required 0", pll_rst); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_loss_in_run();
    test_stable_glitch();
    test_relock_priority();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
